// File: rtl/tt_input_debouncer.sv
// tt_input_debouncer
// Per-bit input conditioner: 2-flop synchroniser, consecutive-sample
// debounce counter, registered clean level and one-cycle rise/fall strobes.
// Every output is a flop, so no input reaches an output combinationally.
module tt_input_debouncer #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    // Counter width: enough to hold DEBOUNCE_CYCLES-1, never narrower than 1 bit.
    localparam int unsigned CW = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]         sync_s1;
    logic [WIDTH-1:0]         sync_s2;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;
    logic [WIDTH-1:0]         clean_d;
    logic [WIDTH-1:0]         rise_d;
    logic [WIDTH-1:0]         fall_d;

    // Two-flop synchroniser; keeps shifting regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= raw_in;
            sync_s2 <= sync_s1;
        end
    end

    // Per-bit debounce decision: clear on match, accept at the terminal count, else count up.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_out;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync_s2[i] == clean_out[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]   = '0;
                clean_d[i] = sync_s2[i];
                rise_d[i]  = sync_s2[i];
                fall_d[i]  = ~sync_s2[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Debounce state and strobes; state holds and strobes drop while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            clean_out  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else if (ena) begin
            cnt_q      <= cnt_d;
            clean_out  <= clean_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            any_change <= |(rise_d | fall_d);
        end else begin
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tt_input_debouncer.sv
// Testbench for tt_input_debouncer (WIDTH=8, DEBOUNCE_CYCLES=4):
// directed vector table, hand-written corner sequences, then randomized
// stimulus compared against a sliding-window reference model.
module tb_tt_input_debouncer;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] raw_in;
    logic [7:0] clean_out;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic       any_change;

    int n_tests = 0;
    int n_fail  = 0;

    tt_input_debouncer #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A bit accepts a new level once the last D enabled-edge synchronised
    // samples all disagree with the current clean level; the window then restarts.
    logic [7:0]   m_clean, m_rise, m_fall;
    logic         m_any;
    logic [7:0]   m_old, m_new;   // raw samples taken two edges ago / one edge ago
    logic [D-1:0] m_win  [8];
    int           m_fill [8];

    task automatic model_reset();
        m_clean = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        m_old = '0; m_new = '0;
        for (int b = 0; b < 8; b++) begin
            m_win[b]  = '0;
            m_fill[b] = 0;
        end
    endtask

    task automatic model_step();
        logic [7:0] seen;
        if (!rst_n) begin
            model_reset();
        end else begin
            seen  = m_old;
            m_old = m_new;
            m_new = raw_in;
            m_rise = '0;
            m_fall = '0;
            if (ena) begin
                for (int b = 0; b < 8; b++) begin
                    m_win[b] = {m_win[b][D-2:0], seen[b]};
                    if (m_fill[b] < D) m_fill[b]++;
                    if (m_fill[b] == D && m_win[b] == {D{~m_clean[b]}}) begin
                        m_clean[b] = seen[b];
                        m_rise[b]  = seen[b];
                        m_fall[b]  = ~seen[b];
                        m_fill[b]  = 0;
                    end
                end
            end
            m_any = |(m_rise | m_fall);
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [24:0] pk(input logic [7:0] c, input logic [7:0] r,
                                       input logic [7:0] f, input logic a);
        return {c, r, f, a};
    endfunction

    function automatic logic [24:0] outs();
        return {clean_out, rise_pulse, fall_pulse, any_change};
    endfunction

    task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got clean=%h rise=%h fall=%h any=%b, expected clean=%h rise=%h fall=%h any=%b",
                     name, act[24:17], act[16:9], act[8:1], act[0],
                     exp[24:17], exp[16:9], exp[8:1], exp[0]);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic       ena;
        logic [7:0] raw;
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } vec_t;

    vec_t tbl [21];

    initial begin
        int rises;
        int waited;

        // Clean rise on bit 0, rise of bit 7, then simultaneous 81 -> 18.
        tbl[0]  = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1};
        tbl[6]  = '{1'b1, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[7]  = '{1'b1, 8'h81, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 8'h81, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{1'b1, 8'h81, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 8'h81, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{1'b1, 8'h81, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[12] = '{1'b1, 8'h81, 8'h81, 8'h80, 8'h00, 1'b1};
        tbl[13] = '{1'b1, 8'h81, 8'h81, 8'h00, 8'h00, 1'b0};
        tbl[14] = '{1'b1, 8'h18, 8'h81, 8'h00, 8'h00, 1'b0};
        tbl[15] = '{1'b1, 8'h18, 8'h81, 8'h00, 8'h00, 1'b0};
        tbl[16] = '{1'b1, 8'h18, 8'h81, 8'h00, 8'h00, 1'b0};
        tbl[17] = '{1'b1, 8'h18, 8'h81, 8'h00, 8'h00, 1'b0};
        tbl[18] = '{1'b1, 8'h18, 8'h81, 8'h00, 8'h00, 1'b0};
        tbl[19] = '{1'b1, 8'h18, 8'h18, 8'h18, 8'h81, 1'b1};
        tbl[20] = '{1'b1, 8'h18, 8'h18, 8'h00, 8'h00, 1'b0};

        // ---- reset with all inputs high ----
        rst_n  = 1'b0;
        ena    = 1'b1;
        raw_in = 8'hFF;
        model_reset();
        #1;
        chk("reset_t0", outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("reset_hold%0d", k), outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));
        end
        rst_n = 1'b1;
        tick();
        chk("reset_release", outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));

        // Restart from an all-low baseline.
        rst_n  = 1'b0;
        raw_in = 8'h00;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        // ---- bounce reject on bit 3: 3 high, 1 low, then hold high ----
        rises = 0;
        raw_in = 8'h08;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rise_pulse[3]) rises++;
            chk($sformatf("bounce_burst%0d", k), outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));
        end
        raw_in = 8'h00;
        tick();
        if (rise_pulse[3]) rises++;
        chk("bounce_gap", outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));
        raw_in = 8'h08;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (rise_pulse[3]) rises++;
            if (k < 6) chk($sformatf("bounce_hold%0d", k), outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));
            else       chk("bounce_accept", outs(), pk(8'h08, 8'h08, 8'h00, 1'b1));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rise_pulse[3]) rises++;
        end
        chk32("bounce_rise_count", rises, 1);

        // Back to all low.
        raw_in = 8'h00;
        for (int k = 0; k < 8; k++) tick();
        chk("baseline_low", outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));

        // ---- vector table ----
        for (int i = 0; i < 21; i++) begin
            ena    = tbl[i].ena;
            raw_in = tbl[i].raw;
            tick();
            chk($sformatf("vec%0d", i), outs(), pk(tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].any));
        end

        // ---- ena freeze during pending rise of bit 0 at count 2 ----
        raw_in = 8'h19;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("freeze_pre%0d", k), outs(), pk(8'h18, 8'h00, 8'h00, 1'b0));
        end
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("freeze_low%0d", k), outs(), pk(8'h18, 8'h00, 8'h00, 1'b0));
        end
        ena = 1'b1;
        tick();
        chk("freeze_resume1", outs(), pk(8'h18, 8'h00, 8'h00, 1'b0));
        tick();
        chk("freeze_resume2", outs(), pk(8'h19, 8'h01, 8'h00, 1'b1));

        // ---- async reset mid-operation ----
        raw_in = 8'hFF;
        waited = 0;
        while (clean_out != 8'hFF && waited < 20) begin
            tick();
            waited++;
        end
        chk32("reach_ff", int'(clean_out), 32'hFF);
        tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_clear", outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            if (k < 5) chk($sformatf("post_rst_edge%0d", k), outs(), pk(8'h00, 8'h00, 8'h00, 1'b0));
            else       chk("post_rst_edge5", outs(), pk(8'hFF, 8'hFF, 8'h00, 1'b1));
        end
        tick();
        chk("post_rst_quiet", outs(), pk(8'hFF, 8'h00, 8'h00, 1'b0));

        // ---- randomized stimulus against the reference model ----
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(3) == 0) raw_in = raw_in ^ 8'($urandom & $urandom & $urandom);
            ena = ($urandom_range(7) != 0);
            tick();
            chk($sformatf("rand%0d", k), outs(), pk(m_clean, m_rise, m_fall, m_any));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_input_debouncer.md
# tt_input_debouncer

Per-bit input conditioner that sits directly upstream of the chip's top-level combinational logic. It takes the raw `ui_in` pad bits, which are asynchronous, bouncy switch and button signals. It synchronises each bit into `clk`, debounces it with a consecutive-sample counter, and drives a clean level plus one-cycle rise/fall strobes. The top-level logic consumes `clean_out` in place of raw `ui_in`.

## Interface
Parameters:
- `WIDTH`, default 8: number of independent input bits.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before `clean_out` accepts a new level. Legal range is 2..65536.

Ports:
- `clk`, input, 1: single clock. All state is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low. Assertion is asynchronous; deassertion is registered on `clk`.
- `ena`, input, 1: design enable. While low, all debouncer state holds.
- `raw_in`, input, WIDTH: raw pad inputs, asynchronous to `clk`.
- `clean_out`, output, WIDTH: debounced, synchronised level per bit.
- `rise_pulse`, output, WIDTH: one-cycle strobe when the matching `clean_out` bit goes 0→1.
- `fall_pulse`, output, WIDTH: one-cycle strobe when the matching `clean_out` bit goes 1→0.
- `any_change`, output, 1: OR of all `rise_pulse` and `fall_pulse` bits, registered in the same cycle as the strobes.

## Operation
- Each bit has its own independent datapath, with no sharing between bits:
  - 2-flop synchroniser: `s1 <= raw_in[i]`, then `s2 <= s1`.
  - Counter `cnt`, `CW = max(1, $clog2(DEBOUNCE_CYCLES))` bits wide.
  - Registered level `clean_out[i]`.
- Per-bit update each `clk` edge with `ena` high:
  - If `s2 == clean_out[i]`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `clean_out[i] <= s2` and `cnt <= 0`.
    - Assert `rise_pulse[i]` if `s2` is 1, otherwise assert `fall_pulse[i]`.
  - Else: `cnt <= cnt + 1`.
  - The counter never wraps; it is always cleared at its terminal value or on a match.
- Pulses are registered. They are high for exactly the one cycle in which the new `clean_out` value first appears, and 0 otherwise.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised samples clears `cnt` when the input returns. `clean_out` does not change and no pulse is produced.
- `ena` low:
  - The synchronisers still shift.
  - `cnt` and `clean_out` hold.
  - `rise_pulse`, `fall_pulse` and `any_change` are forced to 0 on the next edge.
- Simultaneous changes on several bits are handled independently. Several pulse bits may be high in the same cycle.

## Timing
- Reset values: `s1`, `s2`, `cnt`, `clean_out`, `rise_pulse`, `fall_pulse` and `any_change` are all 0.
- Reset mid-count discards the count. After release, a bit held at 1 needs the full latency again.
- Latency is counted in edges, where edge 0 is the first edge that samples a new stable `raw_in` level:
  - `s2` changes after edge 1.
  - The first mismatch is counted at edge 2.
  - `clean_out` and the pulse update at edge `DEBOUNCE_CYCLES+1`.
  - Total latency is `DEBOUNCE_CYCLES+2` edges, with `ena` continuously high.
- Minimum spacing between two accepted transitions on one bit is `DEBOUNCE_CYCLES` cycles.
- There is no combinational path from any input to any output.

## Test plan
Run all scenarios with `WIDTH=8` and `DEBOUNCE_CYCLES=4`.
- Reset: drive `rst_n=0` with `raw_in=8'hFF`. All outputs must read 0 during reset and on the first edge after release.
- Clean rise: `raw_in[0]` goes 0→1 before edge 0 and is held. `clean_out[0]=1`, `rise_pulse[0]=1` and `any_change=1` appear after edge 5 only. All pulse outputs are 0 again after edge 6.
- Bounce reject: on bit 3, drive a pattern of 3 cycles high, 1 cycle low, then hold high.
  - `clean_out[3]` stays 0 through the 3-cycle burst.
  - It rises exactly 6 edges after the start of the final hold.
  - There is exactly one `rise_pulse[3]`.
- Fall plus multi-bit: with `clean_out=8'h81`, set `raw_in=8'h18`. `clean_out` goes to `8'h18` in one cycle, with `rise_pulse=8'h18` and `fall_pulse=8'h81` together.
- `ena` freeze: drop `ena` for 10 cycles during a pending rise at `cnt=2`.
  - No output changes while `ena` is low.
  - After `ena` returns high, `clean_out` updates on the second edge.
- Async reset mid-operation: assert `rst_n` between edges while `clean_out=8'hFF`.
  - Outputs clear immediately, without waiting for an edge.
  - With `raw_in` held at `8'hFF` after release, `rise_pulse=8'hFF` appears at edge 5.
